// File: rtl/disp_sched.sv
// Round-robin display scheduler: picks one of four requesters, strobes its value
// into the display driver and keeps it shown for at least DWELL cycles.
module disp_sched #(
    parameter logic [23:0] DWELL = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [43:0] req_data,
    input  logic        lock,
    output logic [3:0]  ack,
    output logic        disp_sel,
    output logic [10:0] disp_data,
    output logic [1:0]  cur_src,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t      state, state_nx;
    logic [23:0] dwell_cnt, dwell_cnt_nx;
    logic [1:0]  last_grant, last_grant_nx;
    logic [3:0]  ack_nx;
    logic        sel_nx, busy_nx;
    logic [10:0] data_nx;
    logic [1:0]  src_nx;

    logic        found;
    logic [1:0]  winner, cand;

    // Search starts just past the last grant; the last granted index is tried last.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        cand   = last_grant;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // cur_src doubles as the grant register for the LOAD cycle.
    always_comb begin
        state_nx      = state;
        dwell_cnt_nx  = dwell_cnt;
        last_grant_nx = last_grant;
        ack_nx        = 4'b0000;
        sel_nx        = 1'b0;
        busy_nx       = busy;
        data_nx       = disp_data;
        src_nx        = cur_src;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = LOAD;
                    src_nx   = winner;
                    data_nx  = req_data[11*winner +: 11];
                    ack_nx   = 4'b0001 << winner;
                    sel_nx   = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            LOAD: begin
                last_grant_nx = cur_src;
                dwell_cnt_nx  = 24'd0;
                state_nx      = HOLD;
            end
            HOLD: begin
                if (!lock) begin
                    if (dwell_cnt == DWELL - 24'd1) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                    end else begin
                        dwell_cnt_nx = dwell_cnt + 24'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dwell_cnt  <= 24'd0;
            last_grant <= 2'd3;
            ack        <= 4'b0000;
            disp_sel   <= 1'b0;
            disp_data  <= 11'd0;
            cur_src    <= 2'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            dwell_cnt  <= dwell_cnt_nx;
            last_grant <= last_grant_nx;
            ack        <= ack_nx;
            disp_sel   <= sel_nx;
            disp_data  <= data_nx;
            cur_src    <= src_nx;
            busy       <= busy_nx;
        end
    end

endmodule
